serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Bit-serial N-bit adder. The 1-bit full-adder datapath is built structurally from the
//   team gate-library cells XOR2, AND2 and OR2. A carry flip-flop, shift registers and a
//   small FSM iterate that full adder LSB-first over WIDTH cycles.
//   Sits downstream of the gate library as the first sequential lab block that consumes it.
//   Driven by a start/done handshake from a testbench or a higher-level controller.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits (>=2); cycle counter is $clog2(WIDTH+1) bits
// PORTS
//   clk    in   1      single clock, all state updates on posedge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request: latch a/b and begin; honoured only in IDLE
//   a      in   WIDTH  operand A, sampled on accepted start
//   b      in   WIDTH  operand B, sampled on accepted start
//   busy   out  1      high in SHIFT and DONE states
//   done   out  1      one-cycle pulse: sum/cout updated this cycle
//   sum    out  WIDTH  registered result, held until next completion
//   cout   out  1      carry out of MSB (add); not-borrow (sub, see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at posedge): FSM=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry, count=0.
//   FSM IDLE -> SHIFT on start=1. This latches a_sh<=a, b_sh<=b, carry<=cin (0 for add), count<=0.
//   FSM SHIFT, every cycle:
//     s = a_sh[0]^b_sh[0]^carry; c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])), gate cells only.
//     acc <= {s, acc[WIDTH-1:1]}; a_sh,b_sh >>= 1; carry <= c; count <= count+1.
//     When count==WIDTH-1, this is the last bit: next state is DONE.
//   FSM DONE (1 cycle): sum <= final acc, cout <= carry, done=1; next state IDLE.
//   Latency: start accepted at edge t -> done=1 in the cycle after edge t+WIDTH+1;
//     next start accepted at edge t+WIDTH+2 at the earliest.
//   start while busy=1: ignored; no relatch, no effect on the in-flight result.
//   start held high: a new operation starts each time the FSM is in IDLE.
//   a/b changes while busy: no effect; operands are already latched.
//   sum/cout never glitch mid-operation; they change only in the DONE cycle.
//   rst mid-operation: abort, all state/outputs to reset values, no done pulse.
//   Overflow: sum is modulo 2^WIDTH; carry appears only on cout.
//   done and busy are registered, not combinational from start.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined:
//     Adds input port  sub  in  1  (sampled with start). sub=1 computes a-b.
//     Subtraction is done as b_sh <= ~b and cin=1. The inversion uses INV cells.
//     cout=1 means no borrow (a>=b unsigned).
//   Not defined: the sub port is absent and the block is add-only with cin=0.
// TESTING (WIDTH=8)
//   1 start, a=0x5A, b=0x33 -> done after 9 cycles; sum=0x8D, cout=0; busy high 9 cycles.
//   2 a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, carry cleared.
//   3 Pulse start with a=0x01,b=0x01, then start again 3 cycles later with a=0xF0,b=0x0F ->
//     one done only, sum=0x02.
//   4 rst asserted 4 cycles into an op -> no done; busy=0, sum=0, cout=0.
//     A new op 0x10+0x20 then yields 0x30.
//   5 start held high for 30 cycles, a=0x03,b=0x04 -> done every 10 cycles; sum=0x07 each time.
//   6 SERIAL_ADDER_SUB_EN: 0x10-0x01 -> sum=0x0F, cout=1. 0x00-0x01 -> sum=0xFF, cout=0.
//     Sweep all 65536 pairs against a reference model for add and sub.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. A structural full adder built from the
// XOR2/AND2/OR2 cells is iterated LSB-first over WIDTH cycles by a small FSM.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the `sub` port (a-b via ~b and cin=1).
// Leaf gate cells are kept in this file so the block is self-contained.

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             carry;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] b_load;
  logic             cin;
  logic             p_bit, g_bit, pc_bit, s_bit, c_bit;

  // One full-adder slice on the current LSBs.
  XOR2 u_xor_p  (.a(a_sh[0]), .b(b_sh[0]), .y(p_bit));
  XOR2 u_xor_s  (.a(p_bit),   .b(carry),   .y(s_bit));
  AND2 u_and_g  (.a(a_sh[0]), .b(b_sh[0]), .y(g_bit));
  AND2 u_and_pc (.a(carry),   .b(p_bit),   .y(pc_bit));
  OR2  u_or_c   (.a(g_bit),   .b(pc_bit),  .y(c_bit));

`ifdef SERIAL_ADDER_SUB_EN
  logic [WIDTH-1:0] b_inv;

  for (genvar i = 0; i < WIDTH; i++) begin : g_inv
    INV u_inv (.a(b[i]), .y(b_inv[i]));
  end

  // Two's-complement subtract: add ~b with a carry-in of one.
  assign b_load = sub ? b_inv : b;
  assign cin    = sub;
`else
  assign b_load = b;
  assign cin    = 1'b0;
`endif

  // busy derives only from the state register, never from start.
  assign busy = (state_q != StIdle);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (count == LastCount) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath: latch operands, shift one bit per cycle, publish result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= cin;
            count <= '0;
          end
        end
        StShift: begin
          acc   <= {s_bit, acc[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          count <= count + 1'b1;
        end
        StDone: begin
          sum  <= acc;
          cout <= carry;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// Gate-library leaf cells.
module XOR2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module AND2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module OR2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module INV (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule
